// File: rtl/mult_div_if.sv
// Operand/result bundle between the EX-stage control path and the multiply/divide unit.
// master drives the request, slave is the unit that owns HI/LO.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDOp, A, B,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, MDOp, A, B,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shared 2*WIDTH accumulator serves both shift-add multiply and restoring divide.
//
//   state | meaning
//   IDLE  | accepts MULT/MULTU/DIV/DIVU (-> RUN) and MTHI/MTLO (single cycle)
//   RUN   | one iteration per clock; last iteration writes HI/LO and pulses done
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mult_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 is_div;
    logic                 b_zero;
    logic                 neg_main;
    logic                 neg_rem;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 idle_req;
    logic                 accept_iter;
    logic                 last;
    logic                 op_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH-1:0]     hi_res, lo_res;

    assign idle_req    = bus.start && (state_q == IDLE);
    assign accept_iter = idle_req && (bus.MDOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign last        = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign op_signed   = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_DIV);

    // Two's-complement negation of the most negative value yields itself,
    // which is the correct unsigned magnitude.
    assign mag_a = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign mag_b = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply step: acc = {partial high, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opnd});
    assign rem_diff = rem_sh - {1'b0, opnd};
    assign div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc[WIDTH-2:0], rem_ge};

    assign acc_next = is_div ? div_next : mul_next;

    assign mul_res = neg_main ? -mul_next : mul_next;
    assign quo     = neg_main ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem     = neg_rem ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    always_comb begin
        hi_res = mul_res[2*WIDTH-1:WIDTH];
        lo_res = mul_res[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                hi_res = a_raw;
                lo_res = '1;
            end else begin
                hi_res = rem;
                lo_res = quo;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_iter) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (state_q == IDLE) begin
            if (accept_iter) begin
                cnt      <= '0;
                a_raw    <= bus.A;
                b_zero   <= (bus.B == '0);
                neg_main <= op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                neg_rem  <= op_signed && bus.A[WIDTH-1];
                if ((bus.MDOp == OP_DIV) || (bus.MDOp == OP_DIVU)) begin
                    is_div <= 1'b1;
                    opnd   <= mag_b;
                    acc    <= {{WIDTH{1'b0}}, mag_a};
                end else begin
                    is_div <= 1'b0;
                    opnd   <= mag_a;
                    acc    <= {{WIDTH{1'b0}}, mag_b};
                end
            end else if (idle_req && (bus.MDOp == OP_MTHI)) begin
                hi_q <= bus.A;
            end else if (idle_req && (bus.MDOp == OP_MTLO)) begin
                lo_q <= bus.A;
            end
        end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op on HI/LO.
    task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; {exp_hi, exp_lo} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = p; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (op == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.MDOp  = 3'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic finish_iter(input int already, input string tag);
        int n;
        n = already;
        while (bus.busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_cycles"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
    endtask

    task automatic run_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        ref_apply(op, a, b);
        issue(op, a, b);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        finish_iter(0, tag);
    endtask

    task automatic run_single(input logic [2:0] op, input logic [31:0] a, input string tag);
        ref_apply(op, a, 32'($urandom));
        issue(op, a, 32'($urandom));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] old_hi, old_lo;
        int          n, done_seen;
        logic [2:0]  op;

        bus.start = 1'b0;
        bus.MDOp  = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_iter(3'd1, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        @(posedge clk); #1;
        chk("mult_neg_done_drop", 64'(bus.done), 64'd0);
        chk("mult_neg_hold", 64'({bus.HI, bus.LO}), 64'({exp_hi, exp_lo}));

        run_iter(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_iter(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1");
        run_iter(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_iter(3'd4, 32'd7, 32'd2, "divu_small");
        run_iter(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_iter(3'd4, 32'h1234_5678, 32'd0, "divu_zero");
        run_iter(3'd3, 32'hFFFF_FF00, 32'd0, "div_zero");

        // Start while busy must be ignored; operands were latched at acceptance.
        old_hi = exp_hi;
        old_lo = exp_lo;
        ref_apply(3'd1, 32'h0001_2345, 32'hFFFF_8001);
        issue(3'd1, 32'h0001_2345, 32'hFFFF_8001);
        n = 0;
        repeat (9) begin @(posedge clk); #1; n++; end
        chk("ign_hold_hi", 64'(bus.HI), 64'(old_hi));
        chk("ign_hold_lo", 64'(bus.LO), 64'(old_lo));
        bus.start = 1'b1;
        bus.MDOp  = 3'd4;
        bus.A     = 32'hCAFE_F00D;
        bus.B     = 32'd3;
        repeat (3) begin @(posedge clk); #1; n++; end
        bus.start = 1'b0;
        finish_iter(n, "ignore");
        run_single(3'd5, 32'hDEAD_BEEF, "mthi_done_cycle");

        run_iter(3'd3, 32'h7654_3210, 32'h0000_1234, "div_pre_rst");
        issue(3'd3, 32'h8765_4321, 32'd13);
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", 64'({bus.HI, bus.LO}), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        chk("postrst_quiet", 64'(done_seen), 64'd0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) op = 3'($urandom_range(1, 4));
            case (op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    run_iter(op, pick_operand(), pick_operand(), $sformatf("rnd%0d_op%0d", i, op));
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk); #1;
                        chk("rnd_done_drop", 64'(bus.done), 64'd0);
                    end
                end
                default: run_single(op, $urandom, $sformatf("rnd%0d_op%0d", i, op));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
